stove_input_conditioner: RTL and testbench
==========================================

Name: stove_input_conditioner

Overview:
- Front-end stage directly upstream of the stove controller.
- Takes raw, bouncing board buttons (BTN0..BTN3) and switches (SW2, SW3). Produces clean, synchronised, single-cycle command pulses and stable switch levels for the controller to consume.
- Adds auto-repeat on inc/dec and long-press detection for child lock, so the controller sees only one-cycle events.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a new level (10 ms at 50 MHz). Must be >= 1.
- REPEAT_DELAY, 25000000: cycles from the first inc/dec pulse to the first repeat pulse.
- REPEAT_PERIOD, 10000000: cycles between subsequent repeat pulses.
- LOCK_HOLD_CYCLES, 100000000: cycles child_lock must be held (debounced) before lock_toggle fires.
- REPEAT_EN, 1: 1 enables auto-repeat on inc/dec; 0 gives one pulse per press.

Ports:
- clk  in  1  system clock, all logic on rising edge
- sync_nreset  in  1  synchronous, active-low reset
- pwr_raw  in  1  BTN0 raw, active-high
- dec_raw  in  1  BTN1 raw
- inc_raw  in  1  BTN2 raw
- child_lock_raw  in  1  BTN3 raw
- sw_l_raw  in  1  SW2 raw
- sw_h_raw  in  1  SW3 raw
- pwr_pulse  out  1  one-cycle pulse per accepted pwr press
- inc_pulse  out  1  one-cycle pulse per inc press/repeat
- dec_pulse  out  1  one-cycle pulse per dec press/repeat
- lock_toggle  out  1  one-cycle pulse after child_lock long-press
- sw_l  out  1  debounced SW2 level
- sw_h  out  1  debounced SW3 level

Behaviour:
- Reset:
  - Reset is synchronous, active-low, sampled on the clk rising edge.
  - All synchroniser flops, debounced levels, counters and outputs are 0 while sync_nreset = 0.
- Per-input channel (all six inputs):
  - Two-flop synchroniser: raw -> s1 -> s2.
  - Debounced level db, plus counter cnt of width $clog2(DEBOUNCE_CYCLES+1).
  - Each edge, if s2 == db then cnt <= 0.
  - Each edge, if s2 != db: when cnt == DEBOUNCE_CYCLES-1, db <= s2 and cnt <= 0; otherwise cnt <= cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES consecutive cycles never changes db.
- Press event:
  - rise is asserted, registered, on the same edge at which db goes 0 -> 1.
  - Latency: raw sampled 1 at edge k (and held) -> rise is high for exactly one cycle after edge k+1+DEBOUNCE_CYCLES.
- Switches: sw_l and sw_h are the channel db levels. No pulses are generated for switches.
- pwr_pulse: equals the pwr channel rise. No repeat.
- inc/dec auto-repeat, per channel, 2-state FSM:
  - IDLE -> HELD on rise, emitting a pulse and loading rcnt = REPEAT_DELAY-1.
  - In HELD, while db = 1: rcnt decrements; at rcnt == 0, emit a pulse and reload REPEAT_PERIOD-1.
  - HELD -> IDLE when db falls. No pulse on release.
  - REPEAT_EN = 0: HELD never emits.
- inc/dec conflict:
  - While both debounced levels are 1, inc_pulse and dec_pulse are forced 0, including the rise and repeat pulses.
  - Both repeat counters hold while both levels are 1.
- Child lock, FSM states IDLE, TIMING, FIRED:
  - IDLE -> TIMING on rise, with hcnt <= 0.
  - TIMING: hcnt increments each cycle while db = 1. At hcnt == LOCK_HOLD_CYCLES-1, lock_toggle pulses for one cycle and the FSM moves to FIRED.
  - TIMING -> IDLE if db falls first. A short press produces no output.
  - FIRED -> IDLE when db falls. Exactly one toggle per hold, however long the hold lasts.
- Reset mid-operation:
  - Everything returns to 0 / IDLE.
  - A button still held when reset deasserts is treated as a new press: it is re-debounced, then produces its rise and pulse normally.
- Simultaneous events: channels are independent except for the inc/dec conflict rule. pwr and lock_toggle may pulse in the same cycle.
- Counter widths: each counter is $clog2(max count+1) bits. No wrap-around is reachable, because every counter is reset or reloaded before it reaches its limit.

Decomposition:
- Shared package stove_pkg:
  - lock FSM state typedef (IDLE, TIMING, FIRED)
  - repeat FSM state typedef (IDLE, HELD)
  - default timing constants (DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD, LOCK_HOLD_CYCLES) at 50 MHz
- Sub-module stove_btn_debounce:
  - synchroniser + debounce counter + rise generator
  - parameter DEBOUNCE_CYCLES; ports clk, sync_nreset, raw, level, rise
  - instantiated six times
- Repeat and lock FSMs live in the top module.

Test Plan (overrides: DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3, LOCK_HOLD_CYCLES=10):
- Reset: sync_nreset=0 for 3 cycles with all raw inputs = 1 -> all outputs 0 throughout. Release reset, keep pwr_raw=1 -> pwr_pulse high for exactly one cycle, after the 6th edge counting from the first post-reset edge.
- Bounce: pwr_raw toggles 1,0,1,0 each cycle, then holds 1 -> exactly one pwr_pulse, 6 edges after the final stable 1. Glitches of 3 cycles produce no pulse.
- Auto-repeat: inc_raw held 30 cycles -> first inc_pulse at edge k+5, then at +8, then every +3. Release -> no further pulses.
- Conflict: inc_raw and dec_raw pressed on the same cycle and held 20 cycles -> inc_pulse = dec_pulse = 0 throughout. Release dec -> inc repeats resume.
- Child lock: child_lock_raw held 8 cycles -> no lock_toggle. Held 40 cycles -> exactly one lock_toggle, 10 cycles after the debounced level rises.
- Switches and mid-op reset: sw_h_raw set to 1 -> sw_h rises after the 6th edge. Reset asserted mid-repeat -> outputs 0 the next cycle, and behaviour after release is per the reset scenario.

Source files
------------

// File: rtl/stove_pkg.sv
// stove_pkg: FSM state types, default 50 MHz timing and a counter
// width helper shared by the stove input conditioner files.
package stove_pkg;

    typedef enum logic [1:0] {
        LOCK_IDLE,
        LOCK_TIMING,
        LOCK_FIRED
    } lock_state_t;

    typedef enum logic {
        REP_IDLE,
        REP_HELD
    } rep_state_t;

    // 50 MHz: 10 ms, 500 ms, 200 ms, 2 s
    localparam int DEF_DEBOUNCE_CYCLES  = 500_000;
    localparam int DEF_REPEAT_DELAY     = 25_000_000;
    localparam int DEF_REPEAT_PERIOD    = 10_000_000;
    localparam int DEF_LOCK_HOLD_CYCLES = 100_000_000;

    // Bits needed to hold values 0..max_count, never less than 1.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/stove_btn_debounce.sv
// stove_btn_debounce: two-flop synchroniser, stable-count debouncer
// and registered rising-edge pulse for one raw board input.
// Ports: clk, sync_nreset (sync, active-low), raw (async input),
//        level (debounced level), rise (1-cycle pulse on level 0->1).
module stove_btn_debounce
    import stove_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic sync_nreset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!sync_nreset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            rise  <= 1'b0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            rise <= 1'b0;
            // Any sample matching the current level restarts the count,
            // so only an uninterrupted run can flip the level.
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= s2;
                cnt   <= '0;
                rise  <= s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stove_input_conditioner.sv
// stove_input_conditioner: cleans the stove board buttons/switches into
// single-cycle commands with inc/dec auto-repeat and a child-lock hold.
// Ports: clk, sync_nreset (sync, active-low); *_raw board inputs;
//        pwr/inc/dec_pulse, lock_toggle (1-cycle); sw_l, sw_h (levels).
module stove_input_conditioner
    import stove_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY     = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD    = DEF_REPEAT_PERIOD,
    parameter int LOCK_HOLD_CYCLES = DEF_LOCK_HOLD_CYCLES,
    parameter bit REPEAT_EN        = 1'b1
) (
    input  logic clk,
    input  logic sync_nreset,
    input  logic pwr_raw,
    input  logic dec_raw,
    input  logic inc_raw,
    input  logic child_lock_raw,
    input  logic sw_l_raw,
    input  logic sw_h_raw,
    output logic pwr_pulse,
    output logic inc_pulse,
    output logic dec_pulse,
    output logic lock_toggle,
    output logic sw_l,
    output logic sw_h
);

    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                          REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = cnt_width(RMAX - 1);
    localparam logic [RW-1:0] R_DELAY  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] R_PERIOD = RW'(REPEAT_PERIOD - 1);

    localparam int HW = cnt_width(LOCK_HOLD_CYCLES - 1);
    localparam logic [HW-1:0] H_LAST = HW'(LOCK_HOLD_CYCLES - 1);

    // index 0 = inc, 1 = dec
    logic [1:0]    btn_level;
    logic [1:0]    btn_rise;
    logic          lock_level;
    logic          lock_rise;
    logic          unused_pwr_level;
    logic          unused_sw_l_rise;
    logic          unused_sw_h_rise;

    stove_btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_pwr (
        .clk        (clk),
        .sync_nreset(sync_nreset),
        .raw        (pwr_raw),
        .level      (unused_pwr_level),
        .rise       (pwr_pulse)
    );

    stove_btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_inc (
        .clk        (clk),
        .sync_nreset(sync_nreset),
        .raw        (inc_raw),
        .level      (btn_level[0]),
        .rise       (btn_rise[0])
    );

    stove_btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_dec (
        .clk        (clk),
        .sync_nreset(sync_nreset),
        .raw        (dec_raw),
        .level      (btn_level[1]),
        .rise       (btn_rise[1])
    );

    stove_btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_lock (
        .clk        (clk),
        .sync_nreset(sync_nreset),
        .raw        (child_lock_raw),
        .level      (lock_level),
        .rise       (lock_rise)
    );

    stove_btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sw_l (
        .clk        (clk),
        .sync_nreset(sync_nreset),
        .raw        (sw_l_raw),
        .level      (sw_l),
        .rise       (unused_sw_l_rise)
    );

    stove_btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sw_h (
        .clk        (clk),
        .sync_nreset(sync_nreset),
        .raw        (sw_h_raw),
        .level      (sw_h),
        .rise       (unused_sw_h_rise)
    );

    // Holding both inc and dec is ambiguous: suppress both and freeze
    // their repeat timing until one is released.
    logic conflict;
    assign conflict = btn_level[0] & btn_level[1];

    rep_state_t    rep_state [2];
    logic [RW-1:0] rcnt      [2];
    logic [1:0]    rep_fire;

    // Decoded from registers so the first repeat lands exactly
    // REPEAT_DELAY cycles after the press pulse.
    always_comb begin
        rep_fire = '0;
        for (int i = 0; i < 2; i++) begin
            rep_fire[i] = REPEAT_EN
                        && (rep_state[i] == REP_HELD)
                        && btn_level[i]
                        && !conflict
                        && (rcnt[i] == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!sync_nreset) begin
            for (int i = 0; i < 2; i++) begin
                rep_state[i] <= REP_IDLE;
                rcnt[i]      <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                unique case (rep_state[i])
                    REP_IDLE: begin
                        if (btn_rise[i]) begin
                            rep_state[i] <= REP_HELD;
                            rcnt[i]      <= R_DELAY;
                        end
                    end
                    REP_HELD: begin
                        if (!btn_level[i]) begin
                            rep_state[i] <= REP_IDLE;
                        end else if (!conflict) begin
                            if (rcnt[i] == '0) begin
                                rcnt[i] <= R_PERIOD;
                            end else begin
                                rcnt[i] <= rcnt[i] - 1'b1;
                            end
                        end
                    end
                    default: rep_state[i] <= REP_IDLE;
                endcase
            end
        end
    end

    assign inc_pulse = (btn_rise[0] | rep_fire[0]) & ~conflict;
    assign dec_pulse = (btn_rise[1] | rep_fire[1]) & ~conflict;

    lock_state_t   lock_state;
    logic [HW-1:0] hcnt;

    assign lock_toggle = (lock_state == LOCK_TIMING)
                       && lock_level
                       && (hcnt == H_LAST);

    always_ff @(posedge clk) begin
        if (!sync_nreset) begin
            lock_state <= LOCK_IDLE;
            hcnt       <= '0;
        end else begin
            unique case (lock_state)
                LOCK_IDLE: begin
                    if (lock_rise) begin
                        lock_state <= LOCK_TIMING;
                        hcnt       <= '0;
                    end
                end
                LOCK_TIMING: begin
                    if (!lock_level) begin
                        lock_state <= LOCK_IDLE;
                    end else if (hcnt == H_LAST) begin
                        lock_state <= LOCK_FIRED;
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                LOCK_FIRED: begin
                    // One toggle per hold: wait for release.
                    if (!lock_level) begin
                        lock_state <= LOCK_IDLE;
                    end
                end
                default: lock_state <= LOCK_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stove_input_conditioner.sv
// Scoreboard bench: a per-edge reference model queues expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_stove_input_conditioner;

    localparam int DC = 4;
    localparam int RD = 8;
    localparam int RP = 3;
    localparam int LH = 10;

    localparam int PWR = 0;
    localparam int DEC = 1;
    localparam int INC = 2;
    localparam int LCK = 3;
    localparam int SWL = 4;
    localparam int SWH = 5;

    logic       clk = 1'b0;
    logic       sync_nreset = 1'b0;
    logic [5:0] raw = 6'h3f;
    logic       pwr_pulse;
    logic       inc_pulse;
    logic       dec_pulse;
    logic       lock_toggle;
    logic       sw_l;
    logic       sw_h;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    stove_input_conditioner #(
        .DEBOUNCE_CYCLES (DC),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .LOCK_HOLD_CYCLES(LH),
        .REPEAT_EN       (1'b1)
    ) dut (
        .clk           (clk),
        .sync_nreset   (sync_nreset),
        .pwr_raw       (raw[PWR]),
        .dec_raw       (raw[DEC]),
        .inc_raw       (raw[INC]),
        .child_lock_raw(raw[LCK]),
        .sw_l_raw      (raw[SWL]),
        .sw_h_raw      (raw[SWH]),
        .pwr_pulse     (pwr_pulse),
        .inc_pulse     (inc_pulse),
        .dec_pulse     (dec_pulse),
        .lock_toggle   (lock_toggle),
        .sw_l          (sw_l),
        .sw_h          (sw_h)
    );

    // ---------------- reference model ----------------
    // Level rule: a channel flips once its synchronised sample has
    // disagreed with the level for DC edges in a row.
    logic [5:0] raw_p1 = '0;
    logic [5:0] raw_p2 = '0;
    bit         rst_p1 = 1'b1;
    bit         rst_p2 = 1'b1;
    logic [5:0] hist[$];
    logic [5:0] db_m = '0;
    bit         held[6];
    int         nc_cnt[6];
    int         run = 0;
    logic [5:0] exp_q[$];

    function automatic bit rep_step(input int ch, input logic [5:0] rise,
                                    input bit conf);
        bit p;
        p = 1'b0;
        if (rise[ch]) begin
            held[ch]   = 1'b1;
            nc_cnt[ch] = 0;
            p = !conf;
        end else if (held[ch] && db_m[ch]) begin
            if (!conf) begin
                nc_cnt[ch]++;
                p = (nc_cnt[ch] >= RD) && (((nc_cnt[ch] - RD) % RP) == 0);
            end
        end else begin
            held[ch] = 1'b0;
        end
        return p;
    endfunction

    function automatic void model_edge(input logic nrst,
                                       input logic [5:0] r);
        logic [5:0] s2u;
        logic [5:0] old;
        logic [5:0] rise;
        bit         rst_now;
        bit         conf;
        bit         stable;
        bit         p_inc;
        bit         p_dec;
        bit         tog;
        rst_now = !nrst;
        s2u = (rst_now || rst_p1 || rst_p2) ? 6'b0 : raw_p2;
        raw_p2 = raw_p1;
        raw_p1 = r;
        rst_p2 = rst_p1;
        rst_p1 = rst_now;
        if (rst_now) begin
            hist.delete();
            db_m = '0;
            run  = 0;
            for (int c = 0; c < 6; c++) begin
                held[c]   = 1'b0;
                nc_cnt[c] = 0;
            end
            exp_q.push_back(6'b0);
            return;
        end
        hist.push_back(s2u);
        if (hist.size() > DC) void'(hist.pop_front());
        old = db_m;
        if (hist.size() == DC) begin
            for (int c = 0; c < 6; c++) begin
                stable = 1'b1;
                for (int j = 0; j < DC; j++) begin
                    if (hist[j][c] == old[c]) stable = 1'b0;
                end
                if (stable) db_m[c] = ~old[c];
            end
        end
        rise = db_m & ~old;
        conf = db_m[INC] && db_m[DEC];
        p_inc = rep_step(INC, rise, conf);
        p_dec = rep_step(DEC, rise, conf);
        if (rise[LCK]) run = 1;
        else if (db_m[LCK]) run = (run > LH + 1) ? run : run + 1;
        else run = 0;
        tog = (run == LH + 1);
        exp_q.push_back({rise[PWR], p_inc, p_dec, tog,
                         db_m[SWL], db_m[SWH]});
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            model_edge(sync_nreset, raw);
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [5:0] want;
        logic [5:0] got;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                got  = {pwr_pulse, inc_pulse, dec_pulse, lock_toggle,
                        sw_l, sw_h};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL outputs t=%0t got=%b want=%b %s",
                             $time, got, want,
                             "(pwr inc dec lock sw_l sw_h)");
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    int dur[6];

    initial begin
        // reset with every input high, then a clean pwr press
        tick(3);
        sync_nreset = 1'b1;
        raw = 6'b0;
        raw[PWR] = 1'b1;
        tick(15);
        raw[PWR] = 1'b0;
        tick(10);
        // bounce then stable press
        for (int i = 0; i < 4; i++) begin
            raw[PWR] = ~raw[PWR];
            tick(1);
        end
        raw[PWR] = 1'b1;
        tick(12);
        raw[PWR] = 1'b0;
        tick(10);
        // 3-cycle glitches
        for (int i = 0; i < 3; i++) begin
            raw[PWR] = 1'b1;
            tick(3);
            raw[PWR] = 1'b0;
            tick(6);
        end
        // auto-repeat
        raw[INC] = 1'b1;
        tick(30);
        raw[INC] = 1'b0;
        tick(15);
        // inc/dec conflict, then release dec
        raw[INC] = 1'b1;
        raw[DEC] = 1'b1;
        tick(20);
        raw[DEC] = 1'b0;
        tick(25);
        raw[INC] = 1'b0;
        tick(12);
        // child lock short and long holds, pwr in parallel
        raw[LCK] = 1'b1;
        tick(8);
        raw[LCK] = 1'b0;
        tick(15);
        raw[LCK] = 1'b1;
        tick(9);
        raw[PWR] = 1'b1;
        tick(31);
        raw[LCK] = 1'b0;
        raw[PWR] = 1'b0;
        tick(15);
        // switches
        raw[SWH] = 1'b1;
        tick(10);
        raw[SWL] = 1'b1;
        tick(10);
        raw[SWH] = 1'b0;
        raw[SWL] = 1'b0;
        tick(10);
        // reset mid-repeat with inc still held
        raw[INC] = 1'b1;
        tick(18);
        sync_nreset = 1'b0;
        tick(2);
        sync_nreset = 1'b1;
        tick(25);
        raw[INC] = 1'b0;
        tick(10);
        // randomized phase
        for (int ch = 0; ch < 6; ch++) dur[ch] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int ch = 0; ch < 6; ch++) begin
                if (dur[ch] == 0) begin
                    raw[ch] = ~raw[ch];
                    dur[ch] = ($urandom_range(0, 3) == 0) ?
                              int'($urandom_range(1, 3)) :
                              int'($urandom_range(4, 50));
                end
                dur[ch]--;
            end
            sync_nreset = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
            tick(1);
        end
        sync_nreset = 1'b1;
        raw = '0;
        tick(20);
        @(negedge clk);
        #1;
        if (checks < 100) begin
            errors++;
            $display("FAIL check_count got=%0d want>=100", checks);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
